// File: rtl/lock_attempt_controller_if.sv
// Handshake bundle between the lock supervisor and the keypad checker / user buttons.
// The supervisor uses the master view; the keypad side uses the slave view.
interface lock_attempt_controller_if #(
  parameter int ATT_W = 4
);
  logic             equals_in;
  logic             door_status_correct;
  logic             door_status_incorrect;
  logic             equals_out;
  logic             kp_reset;
  logic             unlock;
  logic             locked_out;
  logic [ATT_W-1:0] attempts_left;
  logic             alarm;

  modport master (
    input  equals_in,
    input  door_status_correct,
    input  door_status_incorrect,
    output equals_out,
    output kp_reset,
    output unlock,
    output locked_out,
    output attempts_left,
    output alarm
  );

  modport slave (
    output equals_in,
    output door_status_correct,
    output door_status_incorrect,
    input  equals_out,
    input  kp_reset,
    input  unlock,
    input  locked_out,
    input  attempts_left,
    input  alarm
  );
endinterface

// File: rtl/lock_attempt_controller.sv
// Supervisory sequencer for the dorm-lock keypad: unlock window, failure count, timed lockout.
// Optional feature: define ALARM_EN to drive alarm during lockout and after each non-final failure.
module lock_attempt_controller #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int TMR_W          = 16,
  parameter int ATT_W          = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  lock_attempt_controller_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    UNLOCK  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [ATT_W-1:0] MAX_A    = ATT_W'(MAX_ATTEMPTS);
  localparam logic [ATT_W-1:0] ONE_A    = ATT_W'(1);
  localparam logic [TMR_W-1:0] ONE_T    = TMR_W'(1);
  localparam logic [TMR_W-1:0] UNL_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [ATT_W-1:0] fail_cnt, fail_cnt_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fail_cnt <= '0;
      tmr      <= '0;
    end else begin
      state    <= state_nxt;
      fail_cnt <= fail_cnt_nxt;
      tmr      <= tmr_nxt;
    end
  end

  // Status levels are only honoured in IDLE; correct beats incorrect when both are up.
  always_comb begin
    state_nxt    = state;
    fail_cnt_nxt = fail_cnt;
    tmr_nxt      = tmr;
    case (state)
      IDLE: begin
        if (bus.door_status_correct) begin
          state_nxt    = UNLOCK;
          tmr_nxt      = UNL_LOAD;
          fail_cnt_nxt = '0;
        end else if (bus.door_status_incorrect) begin
          if (fail_cnt == MAX_A - ONE_A) begin
            state_nxt    = LOCKOUT;
            tmr_nxt      = LCK_LOAD;
            fail_cnt_nxt = MAX_A;
          end else begin
            state_nxt    = CLEAR;
            fail_cnt_nxt = fail_cnt + ONE_A;
          end
        end
      end
      CLEAR: begin
        state_nxt = IDLE;
      end
      UNLOCK: begin
        if (tmr == '0) begin
          state_nxt = CLEAR;
        end else begin
          tmr_nxt = tmr - ONE_T;
        end
      end
      LOCKOUT: begin
        if (tmr == '0) begin
          state_nxt    = CLEAR;
          fail_cnt_nxt = '0;
        end else begin
          tmr_nxt = tmr - ONE_T;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Keypad is held in reset in every state except IDLE, so it is clean on return.
  always_comb begin
    bus.equals_out = 1'b0;
    bus.kp_reset   = 1'b1;
    bus.unlock     = 1'b0;
    bus.locked_out = 1'b0;
    bus.alarm      = 1'b0;
    case (state)
      IDLE: begin
        bus.equals_out = bus.equals_in;
        bus.kp_reset   = 1'b0;
      end
      UNLOCK:  bus.unlock     = 1'b1;
      LOCKOUT: bus.locked_out = 1'b1;
      default: ;
    endcase
`ifdef ALARM_EN
    // fail_cnt is zero in CLEAR after an unlock or lockout expiry, non-zero only after a plain failure.
    bus.alarm = (state == LOCKOUT) || ((state == CLEAR) && (fail_cnt != '0));
`endif
  end

  assign bus.attempts_left = MAX_A - fail_cnt;

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Self-checking bench for lock_attempt_controller: directed scenarios plus randomized traffic
// compared every cycle against a countdown-based behavioural model.
module tb_lock_attempt_controller;

  localparam int MAX_ATTEMPTS   = 3;
  localparam int LOCKOUT_CYCLES = 8;
  localparam int UNLOCK_CYCLES  = 4;
  localparam int TMR_W          = 16;
  localparam int ATT_W          = 4;

  logic clk = 1'b0;
  logic reset;

  lock_attempt_controller_if #(.ATT_W(ATT_W)) bus ();

  lock_attempt_controller #(
    .MAX_ATTEMPTS  (MAX_ATTEMPTS),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .UNLOCK_CYCLES (UNLOCK_CYCLES),
    .TMR_W         (TMR_W),
    .ATT_W         (ATT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Model: remaining unlock / lockout cycles, a pending one-cycle clear, and failures so far.
  int m_unl, m_lck, m_fails;
  bit m_clr, m_alarm_clr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_unl <= 0; m_lck <= 0; m_fails <= 0; m_clr <= 1'b0; m_alarm_clr <= 1'b0;
    end else if (m_unl > 0) begin
      m_unl <= m_unl - 1;
      if (m_unl == 1) begin m_clr <= 1'b1; m_alarm_clr <= 1'b0; end
    end else if (m_lck > 0) begin
      m_lck <= m_lck - 1;
      if (m_lck == 1) begin m_clr <= 1'b1; m_alarm_clr <= 1'b0; m_fails <= 0; end
    end else if (m_clr) begin
      m_clr <= 1'b0;
    end else if (bus.door_status_correct) begin
      m_unl   <= UNLOCK_CYCLES;
      m_fails <= 0;
    end else if (bus.door_status_incorrect) begin
      if (m_fails + 1 == MAX_ATTEMPTS) begin
        m_lck   <= LOCKOUT_CYCLES;
        m_fails <= MAX_ATTEMPTS;
      end else begin
        m_fails     <= m_fails + 1;
        m_clr       <= 1'b1;
        m_alarm_clr <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit idle;
    int exp_alarm;
    idle = (m_unl == 0) && (m_lck == 0) && !m_clr;
`ifdef ALARM_EN
    exp_alarm = ((m_lck > 0) || (m_clr && m_alarm_clr)) ? 1 : 0;
`else
    exp_alarm = 0;
`endif
    check("model_equals_out", int'(bus.equals_out), idle ? int'(bus.equals_in) : 0);
    check("model_kp_reset", int'(bus.kp_reset), idle ? 0 : 1);
    check("model_unlock", int'(bus.unlock), (m_unl > 0) ? 1 : 0);
    check("model_locked_out", int'(bus.locked_out), (m_lck > 0) ? 1 : 0);
    check("model_attempts_left", int'(bus.attempts_left), MAX_ATTEMPTS - m_fails);
    check("model_alarm", int'(bus.alarm), exp_alarm);
  end

  // Present a status level for one sampling edge, then drop it.
  task automatic pulse_status(input logic c, input logic i);
    @(posedge clk); #2;
    bus.door_status_correct   = c;
    bus.door_status_incorrect = i;
    @(posedge clk); #2;
    bus.door_status_correct   = 1'b0;
    bus.door_status_incorrect = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int cnt_unl, cnt_kp, cnt_lck, leak;
    reset = 1'b1;
    bus.equals_in             = 1'b1;
    bus.door_status_correct   = 1'b0;
    bus.door_status_incorrect = 1'b0;
    #3;
    check("rst_attempts_left", int'(bus.attempts_left), 3);
    check("rst_unlock", int'(bus.unlock), 0);
    check("rst_locked_out", int'(bus.locked_out), 0);
    check("rst_kp_reset", int'(bus.kp_reset), 0);
    check("rst_equals_out", int'(bus.equals_out), 1);
    check("rst_alarm", int'(bus.alarm), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    idle_cycles(2);

    // Correct: unlock for 4 cycles, then one clear cycle.
    pulse_status(1'b1, 1'b0);
    cnt_unl = 0; cnt_kp = 0;
    repeat (12) begin
      @(negedge clk);
      cnt_unl += int'(bus.unlock);
      cnt_kp  += int'(bus.kp_reset);
      if (bus.attempts_left != 4'd3) leak++;
    end
    check("t1_unlock_cycles", cnt_unl, 4);
    check("t1_kp_reset_cycles", cnt_kp, 5);
    check("t1_attempts_left_dips", leak, 0);

    // One failure: one kp_reset pulse, attempts 3->2, equals passes again.
    #2;
    pulse_status(1'b0, 1'b1);
    check("t2_kp_reset_pulse", int'(bus.kp_reset), 1);
    idle_cycles(1);
    check("t2_kp_reset_done", int'(bus.kp_reset), 0);
    check("t2_attempts_left", int'(bus.attempts_left), 2);
    bus.equals_in = 1'b0; #1;
    check("t2_equals_follow0", int'(bus.equals_out), 0);
    bus.equals_in = 1'b1; #1;
    check("t2_equals_follow1", int'(bus.equals_out), 1);

    // Correct and incorrect together: unlock wins and failures clear.
    pulse_status(1'b1, 1'b1);
    check("t5_unlock", int'(bus.unlock), 1);
    check("t5_attempts_left", int'(bus.attempts_left), 3);
    idle_cycles(6);

    // Two failures then correct.
    pulse_status(1'b0, 1'b1); idle_cycles(1);
    pulse_status(1'b0, 1'b1); idle_cycles(1);
    check("t4_attempts_before", int'(bus.attempts_left), 1);
    pulse_status(1'b1, 1'b0);
    cnt_unl = 0;
    repeat (8) begin @(negedge clk); cnt_unl += int'(bus.unlock); end
    check("t4_unlock_cycles", cnt_unl, 4);
    check("t4_attempts_after", int'(bus.attempts_left), 3);
    #2; idle_cycles(1);

    // Three failures: lockout of 8 cycles, equals gated.
    pulse_status(1'b0, 1'b1); idle_cycles(1);
    pulse_status(1'b0, 1'b1); idle_cycles(1);
    bus.equals_in = 1'b1;
    pulse_status(1'b0, 1'b1);
    check("t3_attempts_in_lockout", int'(bus.attempts_left), 0);
    cnt_lck = 0; leak = 0;
    repeat (12) begin
      @(negedge clk);
      cnt_lck += int'(bus.locked_out);
      if (bus.locked_out && bus.equals_out) leak++;
    end
    check("t3_locked_cycles", cnt_lck, 8);
    check("t3_equals_gated", leak, 0);
    check("t3_attempts_after", int'(bus.attempts_left), 3);
    #2; idle_cycles(1);

    // Reset in lockout cycle 3 drops locked_out without a clock edge.
    pulse_status(1'b0, 1'b1); idle_cycles(1);
    pulse_status(1'b0, 1'b1); idle_cycles(1);
    pulse_status(1'b0, 1'b1);
    idle_cycles(2);
    check("t6_locked_before", int'(bus.locked_out), 1);
    reset = 1'b1; #1;
    check("t6_locked_async", int'(bus.locked_out), 0);
    check("t6_alarm_async", int'(bus.alarm), 0);
    check("t6_kp_reset_async", int'(bus.kp_reset), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check("t6_attempts_after", int'(bus.attempts_left), 3);
    check("t6_locked_after", int'(bus.locked_out), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #2;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      bus.equals_in             = 1'($urandom_range(0, 1));
      bus.door_status_correct   = ($urandom_range(0, 9) == 0);
      bus.door_status_incorrect = ($urandom_range(0, 2) == 0);
    end
    reset = 1'b0;
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
